wb_unit: RTL and testbench

//   Writeback unit: the write-side initiator for RegisterFile's single write port.
//   - Accepts one retired instruction per handshake from the execute stage.
//   - For loads, performs the data-memory read and aligns / sign-extends the result.
//   - Drives rdAddr/rdData/writeEnable for exactly one cycle per accepted instruction.
//   - Exports busy/busy_rd so decode can stall on read-after-write hazards.

---
 rtl/npc_pkg.sv | 21 ++
 rtl/load_align.sv | 25 ++
 rtl/wb_unit.sv | 110 +++++++++++
 tb/tb_wb_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the writeback unit: state encoding,
// load funct3 codes and register-file geometry.
package npc_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REQ,
    WAIT
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Load data alignment: shifts the fetched word down by the byte
// offset, then sign- or zero-extends per the RV32 load width.
module load_align
  import npc_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] w;

  always_comb begin
    w = word_i >> {off_i, 3'b000};
    unique case (1'b1)
      funct3_i == F3_LB:  data_o = {{24{w[7]}}, w[7:0]};
      funct3_i == F3_LBU: data_o = {24'h0, w[7:0]};
      funct3_i == F3_LH:  data_o = {{16{w[15]}}, w[15:0]};
      funct3_i == F3_LHU: data_o = {16'h0, w[15:0]};
      default:            data_o = w;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: owns the register-file write port, performs load
// reads from data memory and exposes the in-flight rd for hazards.
module wb_unit
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  writeEnable,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] busy_rd
);

  wb_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] aligned;
  logic                  hs;
  logic                  in_wb;

  // data_q holds the load address until the response replaces it
  load_align u_align (
    .word_i   (mem_rsp_data),
    .off_i    (data_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (aligned)
  );

  assign in_ready = (state_q == IDLE) || (state_q == WB);
  assign hs       = in_valid && in_ready;
  assign in_wb    = (state_q == WB);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    f3_d    = f3_q;
    data_d  = data_q;
    unique case (1'b1)
      state_q == IDLE,
      state_q == WB: begin
        if (hs) begin
          rd_d    = in_rd;
          wen_d   = in_wen;
          f3_d    = in_funct3;
          data_d  = in_data;
          state_d = in_is_load ? REQ : WB;
        end else begin
          state_d = IDLE;
        end
      end
      state_q == REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      state_q == WAIT: begin
        if (mem_rsp_valid) begin
          data_d  = aligned;
          state_d = WB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      f3_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      f3_q    <= f3_d;
      data_q  <= data_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = mem_req_valid ?
                         {data_q[DATA_WIDTH-1:2], 2'b00} : '0;

  assign rdAddr      = in_wb ? rd_q : '0;
  assign rdData      = in_wb ? data_q : '0;
  assign writeEnable = in_wb && wen_q && (rd_q != '0);

  assign busy    = (state_q != IDLE);
  assign busy_rd = (busy && wen_q) ? rd_q : '0;

endmodule

// File: tb/tb_wb_unit.sv
// Randomized and directed bench for wb_unit against a
// transaction-level model of writebacks and load traffic.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic        writeEnable;
  logic        busy;
  logic [4:0]  busy_rd;

  always #5 clk = ~clk;

  wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_wen        (in_wen),
    .in_is_load    (in_is_load),
    .in_funct3     (in_funct3),
    .in_data       (in_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rdAddr        (rdAddr),
    .rdData        (rdData),
    .writeEnable   (writeEnable),
    .busy          (busy),
    .busy_rd       (busy_rd)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  // model: pending write this cycle, and load progress (0 none, 1 request, 2 waiting)
  bit          m_wb;
  logic [4:0]  m_wb_rd;
  logic        m_wb_wen;
  logic [31:0] m_wb_data;
  int          m_ld;
  logic [4:0]  m_ld_rd;
  logic        m_ld_wen;
  logic [2:0]  m_ld_f3;
  logic [31:0] m_ld_addr;

  function automatic logic [31:0] load_value(logic [31:0] word, logic [31:0] addr,
                                             logic [2:0] f3);
    longint unsigned w;
    longint v;
    w = longint'(word) / (longint'(1) << (8 * int'(addr[1:0])));
    case (f3)
      3'b000: begin v = w % 256;   if (v >= 128)   v -= 256;   end
      3'b100: v = w % 256;
      3'b001: begin v = w % 65536; if (v >= 32768) v -= 65536; end
      3'b101: v = w % 65536;
      default: v = w;
    endcase
    return 32'(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [4:0] brd;
      brd = 5'd0;
      if (m_ld != 0) brd = m_ld_wen ? m_ld_rd : 5'd0;
      else if (m_wb) brd = m_wb_wen ? m_wb_rd : 5'd0;
      chk("in_ready", 32'(in_ready), 32'(m_ld == 0));
      chk("writeEnable", 32'(writeEnable),
          32'(m_wb && m_wb_wen && (m_wb_rd != 5'd0)));
      if (m_wb) begin
        chk("rdAddr", 32'(rdAddr), 32'(m_wb_rd));
        chk("rdData", rdData, m_wb_data);
      end
      chk("busy", 32'(busy), 32'(m_wb || (m_ld != 0)));
      chk("busy_rd", 32'(busy_rd), 32'(brd));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(m_ld == 1));
      if (m_ld == 1) chk("mem_req_addr", mem_req_addr, m_ld_addr & ~32'd3);
    end
  end

  task automatic model_update();
    bit nwb;
    int old;
    nwb = 1'b0;
    old = m_ld;
    if (rst) begin
      m_wb = 1'b0;
      m_ld = 0;
      return;
    end
    if (old == 2 && mem_rsp_valid) begin
      nwb       = 1'b1;
      m_wb_rd   = m_ld_rd;
      m_wb_wen  = m_ld_wen;
      m_wb_data = load_value(mem_rsp_data, m_ld_addr, m_ld_f3);
      m_ld      = 0;
    end else if (old == 1 && mem_req_ready) begin
      m_ld = 2;
    end
    if (old == 0 && in_valid) begin
      if (in_is_load) begin
        m_ld      = 1;
        m_ld_rd   = in_rd;
        m_ld_wen  = in_wen;
        m_ld_f3   = in_funct3;
        m_ld_addr = in_data;
      end else begin
        nwb       = 1'b1;
        m_wb_rd   = in_rd;
        m_wb_wen  = in_wen;
        m_wb_data = in_data;
      end
    end
    m_wb = nwb;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_rd         = 5'd0;
    in_wen        = 1'b0;
    in_is_load    = 1'b0;
    in_funct3     = 3'd0;
    in_data       = 32'd0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
  endtask

  task automatic issue(bit ld, logic [4:0] rd, bit wen, logic [2:0] f3,
                       logic [31:0] d);
    in_valid   = 1'b1;
    in_is_load = ld;
    in_rd      = rd;
    in_wen     = wen;
    in_funct3  = f3;
    in_data    = d;
  endtask

  initial begin
    idle_inputs();
    rst  = 1'b1;
    m_wb = 1'b0;
    m_ld = 0;
    step();
    step();
    rst    = 1'b0;
    cmp_en = 1'b1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset writeEnable", 32'(writeEnable), 32'd0);
    chk("reset mem_req_valid", 32'(mem_req_valid), 32'd0);

    // single ALU op
    issue(1'b0, 5'd5, 1'b1, 3'd0, 32'h1234);
    step();
    in_valid = 1'b0;
    chk("alu we", 32'(writeEnable), 32'd1);
    chk("alu rdAddr", 32'(rdAddr), 32'd5);
    chk("alu rdData", rdData, 32'h1234);
    step();
    chk("alu we once", 32'(writeEnable), 32'd0);

    // back-to-back ALU ops
    for (int i = 1; i <= 3; i++) begin
      issue(1'b0, 5'(i), 1'b1, 3'd0, 32'(i * 16'h111));
      step();
      chk("b2b we", 32'(writeEnable), 32'd1);
      chk("b2b rdAddr", 32'(rdAddr), 32'(i));
      chk("b2b in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();

    // LB with delayed request acceptance
    issue(1'b1, 5'd4, 1'b1, 3'b000, 32'h8000_0003);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("lb req valid", 32'(mem_req_valid), 32'd1);
      chk("lb req addr", mem_req_addr, 32'h8000_0000);
      if (i == 0) step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("lb req drop", 32'(mem_req_valid), 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h80FF_0000;
    step();
    mem_rsp_valid = 1'b0;
    chk("lb we", 32'(writeEnable), 32'd1);
    chk("lb rdData", rdData, 32'hFFFF_FF80);
    step();

    // LHU at offset 2, then same with rd=0
    for (int v = 0; v < 2; v++) begin
      issue(1'b1, (v == 0) ? 5'd6 : 5'd0, 1'b1, 3'b101, 32'h0000_1002);
      mem_req_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hBEEF_1234;
      step();
      mem_rsp_valid = 1'b0;
      chk("lhu rdData", rdData, 32'h0000_BEEF);
      chk("lhu we", 32'(writeEnable), (v == 0) ? 32'd1 : 32'd0);
      chk("lhu busy wb", 32'(busy), 32'd1);
      step();
      chk("lhu busy after", 32'(busy), 32'd0);
    end

    // reset while waiting, stale response afterwards
    issue(1'b1, 5'd9, 1'b1, 3'b010, 32'h40);
    mem_req_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    step();
    mem_rsp_valid = 1'b0;
    chk("rst we", 32'(writeEnable), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);

    // busy_rd tracking through a load
    issue(1'b1, 5'd7, 1'b1, 3'b010, 32'h100);
    step();
    in_valid = 1'b0;
    chk("brd req", 32'(busy_rd), 32'd7);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("brd wait", 32'(busy_rd), 32'd7);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    chk("brd wb", 32'(busy_rd), 32'd7);
    step();
    chk("brd idle", 32'(busy_rd), 32'd0);
    chk("busy idle", 32'(busy), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      in_valid      = ($urandom_range(0, 9) < 6);
      in_is_load    = ($urandom_range(0, 9) < 3);
      in_rd         = 5'($urandom);
      in_wen        = ($urandom_range(0, 4) != 0);
      in_funct3     = 3'($urandom);
      in_data       = $urandom;
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = (m_ld == 2) ? ($urandom_range(0, 9) < 4)
                                  : ($urandom_range(0, 9) == 0);
      mem_rsp_data  = $urandom;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
